// File: rtl/ddr_file_loader_if.sv
// ddr_file_loader_if: byte-stream input plus AXI4 write-address/data/response channels of the file loader.
interface ddr_file_loader_if #(
    parameter int ADDR_W = 32
);
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic              m_axi_awid;
    logic [ADDR_W-1:0] m_axi_awaddr;
    logic [7:0]        m_axi_awlen;
    logic [2:0]        m_axi_awsize;
    logic [1:0]        m_axi_awburst;
    logic              m_axi_awvalid;
    logic              m_axi_awready;
    logic [31:0]       m_axi_wdata;
    logic [3:0]        m_axi_wstrb;
    logic              m_axi_wlast;
    logic              m_axi_wvalid;
    logic              m_axi_wready;
    logic [1:0]        m_axi_bresp;
    logic              m_axi_bvalid;
    logic              m_axi_bready;

    modport master (
        input  s_data, s_valid, m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
        output s_ready, m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
               m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid, m_axi_bready
    );

    modport slave (
        output s_data, s_valid, m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
        input  s_ready, m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
               m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid, m_axi_bready
    );
endinterface

// File: rtl/ddr_file_loader.sv
// ddr_file_loader: packs a size-prefixed byte stream into 32-bit LE words and writes them to DDR as AXI4 INCR bursts.
module ddr_file_loader #(
    parameter int BURST_LEN = 16,
    parameter int ADDR_W    = 32,
    parameter int BUF_AW    = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [31:0]       o_file_size,
    ddr_file_loader_if.master bus
);
    localparam int CW = BUF_AW + 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(4 * BURST_LEN - 1);

    typedef enum logic [2:0] {IDLE, HDR, FILL, AW, W, B, DONE} state_t;
    state_t r_state, w_next;

    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_size, r_remaining, r_word;
    logic [1:0]        r_hdr_cnt, r_bcnt;
    logic [CW-1:0]     r_cnt, r_rd;
    logic              r_error;
    logic [35:0]       r_buf [2**BUF_AW];

    logic        w_acc, w_last_byte, w_push, w_full, w_last_beat;
    logic [31:0] w_word, w_hdr_size;
    logic [3:0]  w_strb;
    logic [35:0] w_beat;

    assign bus.s_ready  = r_state == HDR || r_state == FILL;
    assign w_acc        = bus.s_valid && bus.s_ready;
    assign w_last_byte  = r_remaining == 32'd1;
    assign w_push       = r_state == FILL && w_acc && (r_bcnt == 2'd3 || w_last_byte);
    assign w_full       = r_cnt == CW'(BURST_LEN - 1);
    assign w_word       = r_word | ({24'd0, bus.s_data} << {r_bcnt, 3'b000});
    // strobe covers byte lanes 0..r_bcnt, i.e. the bytes collected including the current one
    assign w_strb       = {r_bcnt == 2'd3, r_bcnt >= 2'd2, r_bcnt != 2'd0, 1'b1};
    assign w_hdr_size   = {bus.s_data, r_size[23:0]};
    assign w_beat       = r_buf[r_rd[BUF_AW-1:0]];
    assign w_last_beat  = r_rd == r_cnt - CW'(1);

    assign bus.m_axi_awid    = 1'b0;
    assign bus.m_axi_awaddr  = r_addr;
    assign bus.m_axi_awlen   = 8'(r_cnt - CW'(1));
    assign bus.m_axi_awsize  = 3'b010;
    assign bus.m_axi_awburst = 2'b01;
    assign bus.m_axi_wdata   = w_beat[31:0];
    assign bus.m_axi_wstrb   = w_beat[35:32];
    assign bus.m_axi_wlast   = w_last_beat;
    assign o_busy            = r_state != IDLE && r_state != DONE;
    assign o_done            = r_state == DONE;
    assign o_error           = r_error;
    assign o_file_size       = r_size;

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        bus.m_axi_awvalid = 1'b0;
        bus.m_axi_wvalid = 1'b0;
        bus.m_axi_bready = 1'b0;
        case (r_state)
            IDLE: w_next = i_start ? HDR : IDLE;
            HDR:  if (w_acc && r_hdr_cnt == 2'd3) w_next = (w_hdr_size == 32'd0) ? DONE : FILL;
            FILL: if (w_push && (w_last_byte || w_full)) w_next = AW;
            AW: begin
                bus.m_axi_awvalid = 1'b1;
                if (bus.m_axi_awready) w_next = W;
            end
            W: begin
                bus.m_axi_wvalid = 1'b1;
                if (bus.m_axi_wready && w_last_beat) w_next = B;
            end
            B: begin
                bus.m_axi_bready = 1'b1;
                if (bus.m_axi_bvalid) w_next = (r_remaining != 32'd0) ? FILL : DONE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_addr      <= '0;
            r_size      <= '0;
            r_remaining <= '0;
            r_word      <= '0;
            r_hdr_cnt   <= '0;
            r_bcnt      <= '0;
            r_cnt       <= '0;
            r_rd        <= '0;
            r_error     <= 1'b0;
        end else begin
            if (r_state == IDLE && i_start) begin
                r_error <= 1'b0;
                r_addr  <= i_base_addr & ~ALIGN_MASK;
            end
            if (r_state == HDR && w_acc) begin
                r_size[{r_hdr_cnt, 3'b000} +: 8] <= bus.s_data;
                r_hdr_cnt   <= r_hdr_cnt + 2'd1;
                r_remaining <= w_hdr_size;
            end
            if (r_state == FILL && w_acc) begin
                r_remaining <= r_remaining - 32'd1;
                r_word      <= w_push ? 32'd0 : w_word;
                r_bcnt      <= w_push ? 2'd0 : r_bcnt + 2'd1;
                if (w_push) r_cnt <= r_cnt + CW'(1);
            end
            if (r_state == W && bus.m_axi_wready) r_rd <= r_rd + CW'(1);
            if (r_state == B && bus.m_axi_bvalid) begin
                r_error <= r_error | (bus.m_axi_bresp != 2'b00);
                r_addr  <= r_addr + ADDR_W'({r_cnt, 2'b00});
                r_cnt   <= '0;
                r_rd    <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_buf[r_cnt[BUF_AW-1:0]] <= {w_strb, w_word};
    end
endmodule

// File: tb/tb_ddr_file_loader.sv
// tb_ddr_file_loader: randomized file transfers against a burst-level reference model with an AXI slave/memory scoreboard.
module tb_ddr_file_loader;
    localparam int BL = 16;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        i_start = 1'b0;
    logic [31:0] i_base_addr = '0;
    logic        o_busy, o_done, o_error;
    logic [31:0] o_file_size;

    ddr_file_loader_if #(.ADDR_W(32)) bus ();

    ddr_file_loader #(.BURST_LEN(BL), .ADDR_W(32), .BUF_AW(4)) dut (
        .clk(clk), .resetn(resetn), .i_start(i_start), .i_base_addr(i_base_addr),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_file_size(o_file_size),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } aw_t;
    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_t;

    aw_t        exp_aw[$];
    w_t         exp_w[$];
    logic [7:0] byte_q[$];
    logic [7:0] payload[$];
    logic [7:0] mem[int];

    int checks = 0, errors = 0, cyc = 0;
    int aw_delay = 0, err_at = -1, b_idx = 0;
    int done_cnt = 0, done_cyc = 0, last_b_cyc = 0, last_acc_cyc = 0;
    bit w_toggle = 0, s_gaps = 0, s_hs = 0;
    int aw_wait = 0;
    bit aw_hold = 0, w_hold = 0, w_tog = 0;
    aw_t aw_h;
    w_t  w_h;
    logic [31:0] w_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // stream source: bytes leave byte_q one per handshake, optionally with idle gaps
    initial begin
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                bus.s_valid = 1'b0;
                s_hs = 0;
            end else begin
                if (s_hs) begin
                    bus.s_valid = 1'b0;
                    s_hs = 0;
                end
                if (!bus.s_valid && byte_q.size() > 0 && (!s_gaps || $urandom_range(0, 2) != 0)) begin
                    bus.s_data = byte_q.pop_front();
                    bus.s_valid = 1'b1;
                end
                if (bus.s_valid && bus.s_ready) begin
                    s_hs = 1;
                    last_acc_cyc = cyc;
                end
            end
        end
    end

    initial begin
        aw_t e;
        bus.m_axi_awready = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                bus.m_axi_awready = 1'b0;
                aw_wait = 0;
                aw_hold = 0;
            end else if (bus.m_axi_awvalid) begin
                if (aw_hold) begin
                    chk("awaddr_stable", bus.m_axi_awaddr, aw_h.addr);
                    chk("awlen_stable", bus.m_axi_awlen, aw_h.len);
                end
                bus.m_axi_awready = aw_wait >= aw_delay;
                aw_wait++;
                if (bus.m_axi_awready) begin
                    aw_wait = 0;
                    aw_hold = 0;
                    w_addr = bus.m_axi_awaddr;
                    if (exp_aw.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL aw_unexpected: got awaddr 0x%0h with no burst expected", bus.m_axi_awaddr);
                    end else begin
                        e = exp_aw.pop_front();
                        chk("awaddr", bus.m_axi_awaddr, e.addr);
                        chk("awlen", bus.m_axi_awlen, e.len);
                        chk("awsize", bus.m_axi_awsize, 3'b010);
                        chk("awburst", bus.m_axi_awburst, 2'b01);
                        chk("awid", bus.m_axi_awid, 1'b0);
                    end
                end else begin
                    aw_hold = 1;
                    aw_h = '{bus.m_axi_awaddr, bus.m_axi_awlen};
                end
            end else begin
                bus.m_axi_awready = 1'b0;
                aw_hold = 0;
            end
        end
    end

    initial begin
        w_t e;
        bus.m_axi_wready = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                bus.m_axi_wready = 1'b0;
                w_hold = 0;
            end else if (bus.m_axi_wvalid) begin
                if (w_hold) begin
                    chk("wdata_stable", bus.m_axi_wdata, w_h.data);
                    chk("wstrb_stable", bus.m_axi_wstrb, w_h.strb);
                    chk("wlast_stable", bus.m_axi_wlast, w_h.last);
                end
                w_tog = !w_tog;
                bus.m_axi_wready = w_toggle ? w_tog : 1'b1;
                if (bus.m_axi_wready) begin
                    w_hold = 0;
                    for (int k = 0; k < 4; k++)
                        if (bus.m_axi_wstrb[k]) mem[int'(w_addr + 32'(k))] = bus.m_axi_wdata[8*k +: 8];
                    w_addr = w_addr + 32'd4;
                    if (exp_w.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL w_unexpected: got wdata 0x%0h with no beat expected", bus.m_axi_wdata);
                    end else begin
                        e = exp_w.pop_front();
                        chk("wdata", bus.m_axi_wdata, e.data);
                        chk("wstrb", bus.m_axi_wstrb, e.strb);
                        chk("wlast", bus.m_axi_wlast, e.last);
                    end
                end else begin
                    w_hold = 1;
                    w_h = '{bus.m_axi_wdata, bus.m_axi_wstrb, bus.m_axi_wlast};
                end
            end else begin
                bus.m_axi_wready = 1'b0;
            end
        end
    end

    initial begin
        bus.m_axi_bvalid = 1'b0;
        bus.m_axi_bresp = 2'b00;
        forever begin
            @(negedge clk);
            if (!resetn) bus.m_axi_bvalid = 1'b0;
            else if (bus.m_axi_bvalid) bus.m_axi_bvalid = 1'b0;
            else if (bus.m_axi_bready) begin
                bus.m_axi_bvalid = 1'b1;
                bus.m_axi_bresp = (b_idx == err_at) ? 2'b10 : 2'b00;
                b_idx++;
                last_b_cyc = cyc;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // reference model: payload split into ceil(n/4) LE words, grouped into bursts of at most BL words
    task automatic build_exp(input logic [31:0] base, input int n, input bit rnd, output int bursts);
        logic [31:0] ab = base & ~32'(4 * BL - 1);
        int words = (n + 3) / 4;
        bursts = 0;
        payload.delete();
        for (int i = 0; i < n; i++) payload.push_back(rnd ? 8'($urandom) : 8'(i));
        for (int w0 = 0; w0 < words; w0 += BL) begin
            int nb = (words - w0 < BL) ? words - w0 : BL;
            exp_aw.push_back('{ab + 32'(4 * w0), 8'(nb - 1)});
            for (int j = 0; j < nb; j++) begin
                logic [31:0] d = '0;
                logic [3:0] s = '0;
                for (int k = 0; k < 4; k++)
                    if (4 * (w0 + j) + k < n) begin
                        d[8*k +: 8] = payload[4 * (w0 + j) + k];
                        s[k] = 1'b1;
                    end
                exp_w.push_back('{d, s, j == nb - 1});
            end
            bursts++;
        end
    endtask

    task automatic start_file(input logic [31:0] base, input int n);
        @(negedge clk);
        i_base_addr = base;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("busy_after_start", o_busy, 1'b1);
        chk("error_cleared", o_error, 1'b0);
        for (int k = 0; k < 4; k++) byte_q.push_back(8'(n >> (8 * k)));
        foreach (payload[i]) byte_q.push_back(payload[i]);
    endtask

    task automatic run_file(input logic [31:0] base, input int n, input bit rnd, input int err, input bit extra_start);
        int bursts, bad = 0;
        logic [31:0] ab = base & ~32'(4 * BL - 1);
        build_exp(base, n, rnd, bursts);
        mem.delete();
        err_at = err;
        b_idx = 0;
        done_cnt = 0;
        start_file(base, n);
        if (extra_start) begin
            repeat (10) @(negedge clk);
            i_base_addr = 32'hF000;
            i_start = 1'b1;
            @(negedge clk);
            i_start = 1'b0;
        end
        for (int t = 0; t < 20000 && done_cnt == 0; t++) @(negedge clk);
        chk("done_seen", done_cnt, 1);
        chk("done_timing", done_cyc, (bursts > 0 ? last_b_cyc : last_acc_cyc) + 1);
        repeat (3) @(negedge clk);
        chk("done_once", done_cnt, 1);
        chk("busy_idle", o_busy, 1'b0);
        chk("file_size", o_file_size, n);
        chk("error_flag", o_error, err >= 0 && err < bursts);
        chk("aw_left", exp_aw.size(), 0);
        chk("w_left", exp_w.size(), 0);
        chk("mem_bytes", mem.num(), n);
        for (int i = 0; i < n; i++)
            if (!mem.exists(int'(ab + 32'(i))) || mem[int'(ab + 32'(i))] !== payload[i]) bad++;
        chk("mem_data", bad, 0);
        exp_aw.delete();
        exp_w.delete();
        byte_q.delete();
    endtask

    initial begin
        int bursts;
        repeat (3) @(negedge clk);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_done", o_done, 1'b0);
        chk("rst_error", o_error, 1'b0);
        chk("rst_s_ready", bus.s_ready, 1'b0);
        chk("rst_valids", {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready}, 3'b000);
        chk("rst_file_size", o_file_size, 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        run_file(32'h1000, 8, 0, -1, 0);
        run_file(32'h1000, 70, 0, -1, 1);
        run_file(32'h1000, 0, 0, -1, 0);

        aw_delay = 5;
        w_toggle = 1;
        s_gaps = 1;
        run_file(32'h1000, 70, 0, -1, 0);
        aw_delay = 0;
        w_toggle = 0;
        s_gaps = 0;

        run_file(32'h2000, 100, 1, 0, 0);
        run_file(32'h2000, 20, 1, -1, 0);

        build_exp(32'h1000, 70, 1, bursts);
        err_at = -1;
        start_file(32'h1000, 70);
        for (int t = 0; t < 2000 && !bus.m_axi_wvalid; t++) @(negedge clk);
        chk("w_phase_reached", bus.m_axi_wvalid, 1'b1);
        resetn = 1'b0;
        byte_q.delete();
        @(negedge clk);
        chk("midrst_valids", {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready}, 3'b000);
        chk("midrst_busy", o_busy, 1'b0);
        chk("midrst_s_ready", bus.s_ready, 1'b0);
        exp_aw.delete();
        exp_w.delete();
        resetn = 1'b1;
        @(negedge clk);
        run_file(32'h3000, 16, 1, -1, 0);

        for (int r = 0; r < 8; r++) begin
            aw_delay = $urandom_range(0, 3);
            w_toggle = 1'($urandom_range(0, 1));
            s_gaps = 1'($urandom_range(0, 1));
            run_file($urandom & 32'h7FFF_FFFF, $urandom_range(1, 200), 1,
                     ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : -1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end
endmodule

// File: doc/ddr_file_loader.md
Name: ddr_file_loader

Overview:
- Hardware file loader between the UART receive path and the DDR AXI4 port.
- Consumes a byte stream framed as the file-transfer protocol's file body: a 4-byte little-endian file size, then that many payload bytes.
- Packs the payload into 32-bit little-endian words and writes them to DDR as AXI4 INCR write bursts from a programmed base address.
- Replaces CPU-driven copying of weights/feature maps into DDR.

Parameters:
BURST_LEN, 16, max beats per AXI burst; power of 2, 1..256
ADDR_W, 32, AXI address width
BUF_AW, 4, log2 of word-buffer depth; must satisfy 2**BUF_AW >= BURST_LEN

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; latches base_addr, begins transfer (ignored when busy=1)
base_addr  in  ADDR_W  DDR destination; bits [log2(4*BURST_LEN)-1:0] forced to 0 internally
s_data  in  8  stream byte
s_valid  in  1  byte valid
s_ready  out  1  byte accepted when s_valid&s_ready
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at completion
error  out  1  sticky; set on any bresp!=0, cleared by start
file_size  out  32  latched header value
m_axi_awid  out  1  always 0
m_axi_awaddr  out  ADDR_W  burst address
m_axi_awlen  out  8  beats-1
m_axi_awsize  out  3  always 3'b010
m_axi_awburst  out  2  always 2'b01
m_axi_awvalid/m_axi_awready  out/in  1  AW handshake
m_axi_wdata  out  32  write data
m_axi_wstrb  out  4  byte strobes
m_axi_wlast  out  1  last beat
m_axi_wvalid/m_axi_wready  out/in  1  W handshake
m_axi_bresp  in  2  response
m_axi_bvalid/m_axi_bready  in/out  1  B handshake

Behaviour:
- Reset (resetn=0 at clk edge): state IDLE; busy, done, error, s_ready, all valid/ready outputs 0; file_size=0; counters, buffer pointers 0. Reset mid-burst abandons the transfer immediately; no further AXI traffic is issued (slave-side cleanup is not required).
- States: IDLE -> HDR -> FILL -> AW -> W -> B -> (FILL | DONE) -> IDLE.
- IDLE: s_ready=0. start -> HDR, busy=1, error=0, next address = aligned base_addr.
- HDR: s_ready=1; 4 bytes accepted LSB first into file_size. After the 4th byte: size==0 -> DONE; else -> FILL, remaining bytes = size.
- FILL: s_ready=1; bytes packed LSB first (byte k of word at bits 8k+7:8k). A word is pushed to the buffer when 4 bytes are collected, or when the last file byte arrives. Unfilled bytes are 0; the pushed strobe covers valid bytes only, e.g. 2 bytes -> 4'b0011. Leave FILL when the buffer holds BURST_LEN words or the final word is pushed; s_ready drops the same cycle.
- AW: awvalid=1; awaddr=current address; awlen=words in buffer-1. awvalid and payload stay stable until awready.
- W: beats drained in order; wvalid held, data/strobe stable until wready; wlast on the final beat. Full words use wstrb=4'hF.
- B: bready=1. On bvalid: bresp!=0 sets error, transfer continues; address += 4*beats. Bytes remaining -> FILL, else DONE.
- DONE: done=1 for exactly one cycle, busy=0 -> IDLE.
- Only one burst outstanding; AW always completes before W starts.
- Bursts never cross 4KB: alignment plus BURST_LEN*4 <= 1024.
- Byte count is 32 bits. Word count = ceil(size/4).
- start while busy is ignored. s_valid in IDLE is not consumed.

Test Plan:
- base=0x1000, BURST_LEN=16, header 08 00 00 00, bytes 00..07 -> one burst: awaddr=0x1000, awlen=1; wdata 0x03020100, 0x07060504; wstrb F,F; wlast on beat 2; done one cycle after B.
- size=70, bytes i=0..69 -> two bursts: awaddr 0x1000 awlen 15, then 0x1040 awlen 1. Last beat wdata=0x00004544, wstrb=4'b0011. done once.
- Header 00 00 00 00 -> no AW/W activity; done pulses one cycle after the 4th header byte; file_size=0.
- awready delayed 5 cycles, wready toggled every other cycle, s_valid gapped -> awaddr/wdata/wstrb stable while not accepted; AXI memory contents identical to the no-stall run.
- bresp=2'b10 on the first of two bursts -> error=1 sticky, second burst still written, done pulses; next start clears error.
- resetn asserted during the W phase of burst 1 -> next cycle all valids 0, busy=0; a new start then completes a 16-byte file correctly.
